painterengine_gpu_writer_scheduler: RTL and testbench

- Round-robin scheduler that shares the single GPU DMA writer between 4 requesting channels.
- Selects one channel and drives the writer's one-hot router and active-low reset.
- Holds the writer out of reset until done or error, then returns a per-channel done/error pulse.
- Resets the writer between jobs, since the writer's done/error states are sticky until reset.

---
 rtl/painterengine_gpu_pkg.sv | 23 ++
 rtl/painterengine_gpu_rr_arbiter4.sv | 29 ++
 rtl/painterengine_gpu_writer_scheduler.sv | 144 ++++++++++++++
 tb/tb_painterengine_gpu_writer_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared definitions for the PainterEngine GPU writer path: writer error codes,
// scheduler state encodings and a one-hot helper.
package painterengine_gpu_pkg;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_OK             = 3'b000;
  localparam err_code_t ERR_ROUTER         = 3'b001;
  localparam err_code_t ERR_ADDRESS        = 3'b010;
  localparam err_code_t ERR_ADDRESS_RESP   = 3'b011;
  localparam err_code_t ERR_DATA_TIMEOUT   = 3'b100;
  localparam err_code_t ERR_SCHED_WATCHDOG = 3'b101;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/painterengine_gpu_rr_arbiter4.sv
// Combinational 4-way round-robin pick: searches last+1, last+2, last+3, last.
module painterengine_gpu_rr_arbiter4
  import painterengine_gpu_pkg::*;
(
  input  logic [3:0] request_i,
  input  logic [1:0] last_i,
  output logic [3:0] grant_o,
  output logic [1:0] winner_o,
  output logic       valid_o
);

  logic [1:0] idx;

  always_comb begin
    grant_o  = '0;
    winner_o = last_i;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = last_i + i[1:0];
      if (!valid_o && request_i[idx]) begin
        valid_o  = 1'b1;
        winner_o = idx;
        grant_o  = onehot4(idx);
      end
    end
  end

endmodule

// File: rtl/painterengine_gpu_writer_scheduler.sv
// Round-robin scheduler sharing the single GPU DMA writer between 4 channels;
// the writer is reset between jobs because its done/error levels are sticky.
module painterengine_gpu_writer_scheduler
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_CHANNELS      = 4,
  parameter int PARAM_RESET_HOLD    = 4,
  parameter int PARAM_WATCHDOG_BITS = 20
) (
  input  logic                      i_wire_clock,
  input  logic                      i_wire_reset,
  input  logic [PARAM_CHANNELS-1:0] i_wire_request,
  output logic [PARAM_CHANNELS-1:0] o_wire_grant,
  output logic [PARAM_CHANNELS-1:0] o_wire_done,
  output logic [PARAM_CHANNELS-1:0] o_wire_error,
  output logic [2:0]                o_wire_error_type,
  output logic                      o_wire_busy,
  output logic [PARAM_CHANNELS-1:0] o_wire_writer_router,
  output logic                      o_wire_writer_resetn,
  input  logic                      i_wire_writer_done,
  input  logic                      i_wire_writer_error,
  input  logic [2:0]                i_wire_writer_error_type
);

  localparam int HOLD_W = (PARAM_RESET_HOLD > 1) ? $clog2(PARAM_RESET_HOLD) : 1;

  logic [1:0]                     state_q, state_d;
  logic [PARAM_CHANNELS-1:0]      grant_q, grant_d;
  logic [PARAM_CHANNELS-1:0]      done_q, done_d;
  logic [PARAM_CHANNELS-1:0]      error_q, error_d;
  logic [2:0]                     etype_q, etype_d;
  logic                           busy_q, busy_d;
  logic [PARAM_CHANNELS-1:0]      router_q, router_d;
  logic                           resetn_q, resetn_d;
  logic [1:0]                     rr_last_q, rr_last_d;
  logic [PARAM_WATCHDOG_BITS-1:0] wd_q, wd_d;
  logic [HOLD_W-1:0]              hold_q, hold_d;

  logic [3:0] arb_grant;
  logic [1:0] arb_winner;
  logic       arb_valid;

  painterengine_gpu_rr_arbiter4 u_arb (
    .request_i (i_wire_request),
    .last_i    (rr_last_q),
    .grant_o   (arb_grant),
    .winner_o  (arb_winner),
    .valid_o   (arb_valid)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    error_d   = '0;
    etype_d   = etype_q;
    router_d  = router_q;
    resetn_d  = resetn_q;
    rr_last_d = rr_last_q;
    wd_d      = wd_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        resetn_d = 1'b0;
        router_d = '0;
        grant_d  = '0;
        if (arb_valid) begin
          grant_d   = arb_grant;
          router_d  = arb_grant;
          rr_last_d = arb_winner;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        resetn_d = 1'b1;
        wd_d     = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        wd_d = wd_q + 1'b1;
        // Error outranks done; the watchdog only fires when the writer is silent.
        if (i_wire_writer_error) begin
          error_d = grant_q;
          etype_d = i_wire_writer_error_type;
        end else if (i_wire_writer_done) begin
          done_d = grant_q;
        end else if (&wd_q) begin
          error_d = grant_q;
          etype_d = ERR_SCHED_WATCHDOG;
        end
        if (i_wire_writer_error || i_wire_writer_done || (&wd_q)) begin
          state_d  = ST_FLUSH;
          resetn_d = 1'b0;
          router_d = '0;
          grant_d  = '0;
          hold_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (hold_q == HOLD_W'(PARAM_RESET_HOLD - 1)) state_d = ST_IDLE;
        else                                           hold_d  = hold_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      error_q   <= '0;
      etype_q   <= '0;
      busy_q    <= 1'b0;
      router_q  <= '0;
      resetn_q  <= 1'b0;
      rr_last_q <= 2'd3;
      wd_q      <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      error_q   <= error_d;
      etype_q   <= etype_d;
      busy_q    <= busy_d;
      router_q  <= router_d;
      resetn_q  <= resetn_d;
      rr_last_q <= rr_last_d;
      wd_q      <= wd_d;
      hold_q    <= hold_d;
    end
  end

  assign o_wire_grant         = grant_q;
  assign o_wire_done          = done_q;
  assign o_wire_error         = error_q;
  assign o_wire_error_type    = etype_q;
  assign o_wire_busy          = busy_q;
  assign o_wire_writer_router = router_q;
  assign o_wire_writer_resetn = resetn_q;

endmodule

// File: tb/tb_painterengine_gpu_writer_scheduler.sv
// Bench for the GPU writer scheduler: a scripted writer model, per-scenario tasks
// and a scoreboard of expected done/error pulses.
module tb_painterengine_gpu_writer_scheduler;

  localparam int HOLD = 4;
  localparam int WDB  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant, done, error, router;
  logic [2:0] etype, wet;
  logic       busy, resetn, wdone, werr;

  typedef struct packed {
    logic [3:0] done;
    logic [3:0] err;
    logic [2:0] et;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  painterengine_gpu_writer_scheduler #(
    .PARAM_CHANNELS      (4),
    .PARAM_RESET_HOLD    (HOLD),
    .PARAM_WATCHDOG_BITS (WDB)
  ) dut (
    .i_wire_clock             (clk),
    .i_wire_reset             (rst),
    .i_wire_request           (req),
    .o_wire_grant             (grant),
    .o_wire_done              (done),
    .o_wire_error             (error),
    .o_wire_error_type        (etype),
    .o_wire_busy              (busy),
    .o_wire_writer_router     (router),
    .o_wire_writer_resetn     (resetn),
    .i_wire_writer_done       (wdone),
    .i_wire_writer_error      (werr),
    .i_wire_writer_error_type (wet)
  );

  // Every done/error pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done != 4'b0 || error != 4'b0)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: done=%b error=%b, required no pulse", done, error);
      end else begin
        e = sb.pop_front();
        if (done !== e.done || error !== e.err || (e.err != 4'b0 && etype !== e.et)) begin
          errors++;
          $display("FAIL pulse: done=%b error=%b type=%b, required done=%b error=%b type=%b",
                   done, error, etype, e.done, e.err, e.et);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic wait_grant(output logic [3:0] g, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (grant == 4'b0 && n < 100);
    g = grant;
  endtask

  // Starts on the first RUN cycle; ends on the cycle the pulse is visible.
  task automatic run_job(input int cyc, input logic d, input logic e,
                         input logic [2:0] et, input logic [3:0] ch);
    exp_t x;
    repeat (cyc - 1) @(negedge clk);
    x.done = (d && !e) ? ch : 4'b0;
    x.err  = e ? ch : 4'b0;
    x.et   = et;
    sb.push_back(x);
    wdone = d;
    werr  = e;
    wet   = et;
    @(negedge clk);
    wdone = 1'b0;
    werr  = 1'b0;
    wet   = 3'b0;
  endtask

  task automatic test_reset;
    logic [3:0] g;
    int n;
    logic bad;
    rst = 1'b1; req = 4'b0001; wdone = 1'b0; werr = 1'b0; wet = 3'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, done, error, etype, busy, router, resetn} !== 21'b0) begin
      errors++;
      $display("FAIL reset_outputs: grant=%b done=%b error=%b type=%b busy=%b router=%b resetn=%b, required all 0",
               grant, done, error, etype, busy, router, resetn);
    end
    rst = 1'b0;
    wait_grant(g, n);
    checks++;
    if (g !== 4'b0001 || n > 2 || router !== 4'b0001 || resetn !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b after %0d cycles router=%b resetn=%b, required 0001 within 2, router 0001, resetn 0",
               g, n, router, resetn);
    end
    @(negedge clk);
    checks++;
    if (resetn !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL setup_release: resetn=%b busy=%b, required 1 1", resetn, busy);
    end
    run_job(10, 1'b1, 1'b0, 3'b0, 4'b0001);
    checks++;
    if (grant !== 4'b0 || resetn !== 1'b0 || router !== 4'b0) begin
      errors++;
      $display("FAIL flush_entry: grant=%b resetn=%b router=%b, required 0 0 0", grant, resetn, router);
    end
    n = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (grant == 4'b0 && resetn) bad = 1'b1;
    end while (grant == 4'b0 && n < 100);
    checks++;
    if (n !== HOLD + 1 || bad !== 1'b0 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL regrant_latency: grant=%b after %0d cycles resetn_glitch=%b, required 0001 after %0d, no glitch",
               grant, n, bad, HOLD + 1);
    end
    @(negedge clk);
    run_job(3, 1'b1, 1'b0, 3'b0, 4'b0001);
    req = 4'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_jobs: busy=%b grant=%b, required 0 0", busy, grant);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] g;
    logic [3:0] seq [5];
    int n;
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g, n);
      checks++;
      if (g !== seq[i] || (i > 0 && n !== HOLD + 1)) begin
        errors++;
        $display("FAIL rr_grant_%0d: grant=%b after %0d cycles, required %b", i, g, n, seq[i]);
      end
      @(negedge clk);
      run_job(5, 1'b1, 1'b0, 3'b0, seq[i]);
    end
    req = 4'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_error_priority;
    logic [3:0] g;
    int n;
    req = 4'b0100;
    wait_grant(g, n);
    checks++;
    if (g !== 4'b0100) begin
      errors++;
      $display("FAIL errprio_grant: grant=%b, required 0100", g);
    end
    @(negedge clk);
    run_job(4, 1'b1, 1'b1, 3'b010, 4'b0100);
    checks++;
    if (error !== 4'b0100 || done !== 4'b0 || etype !== 3'b010) begin
      errors++;
      $display("FAIL errprio_pulse: error=%b done=%b type=%b, required 0100 0000 010", error, done, etype);
    end
    req = 4'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_watchdog;
    logic [3:0] g;
    int n;
    exp_t x;
    req = 4'b0010;
    wait_grant(g, n);
    checks++;
    if (g !== 4'b0010) begin
      errors++;
      $display("FAIL wd_grant: grant=%b, required 0010", g);
    end
    @(negedge clk);
    x.done = 4'b0; x.err = 4'b0010; x.et = 3'b101;
    sb.push_back(x);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (error == 4'b0 && n < 200);
    checks++;
    if (n !== (1 << WDB) || resetn !== 1'b0 || grant !== 4'b0) begin
      errors++;
      $display("FAIL wd_expiry: pulse after %0d cycles resetn=%b grant=%b, required %0d cycles, resetn 0, grant 0",
               n, resetn, grant, 1 << WDB);
    end
    req = 4'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    logic [3:0] g;
    int n;
    req = 4'b0010;
    wait_grant(g, n);
    checks++;
    if (g !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_grant: grant=%b, required 0010", g);
    end
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({grant, done, error, busy, router, resetn} !== 18'b0) begin
      errors++;
      $display("FAIL midrst_async: grant=%b done=%b error=%b busy=%b router=%b resetn=%b, required all 0",
               grant, done, error, busy, router, resetn);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_grant(g, n);
    checks++;
    if (g !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_regrant: grant=%b, required 0010", g);
    end
    @(negedge clk);
    run_job(4, 1'b1, 1'b0, 3'b0, 4'b0010);
  endtask

  task automatic test_drop_request;
    logic [3:0] g;
    int n;
    req = 4'b1001;
    wait_grant(g, n);
    checks++;
    if (g !== 4'b1000) begin
      errors++;
      $display("FAIL drop_grant: grant=%b, required 1000", g);
    end
    repeat (3) @(negedge clk);
    req = 4'b0001;
    run_job(6, 1'b1, 1'b0, 3'b0, 4'b1000);
    wait_grant(g, n);
    checks++;
    if (g !== 4'b0001 || n !== HOLD + 1) begin
      errors++;
      $display("FAIL drop_next_grant: grant=%b after %0d cycles, required 0001 after %0d", g, n, HOLD + 1);
    end
    @(negedge clk);
    run_job(3, 1'b1, 1'b0, 3'b0, 4'b0001);
    req = 4'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_error_priority();
    test_watchdog();
    test_reset_mid_run();
    test_drop_request();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d pulses outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
